branch_predictor: RTL and testbench
===================================

# branch_predictor

Direct-mapped branch target buffer with per-entry saturating counters, parametrised in entry count and counter width. Sits beside the IF-stage PC register. The IF stage performs a combinational lookup on the fetch PC, so a predicted-taken branch redirects the PC one cycle after fetch. Branch resolution in EX trains the table, so mispredicted branches flush only in that case and not on every taken branch.

## Interface
Parameters:
- ENTRIES, 16: number of table entries; power of two, 4..256. IDX_W = log2(ENTRIES).
- CNT_W, 2: saturating counter width, 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears the table and the statistics.
- lk_pc  in  32  fetch PC (IF stage).
- pred_taken  out  1  lookup hit and counter MSB = 1; combinational.
- pred_target  out  32  stored target on hit, else 32'h0; combinational.
- upd_valid  in  1  a resolved branch is in EX this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual branch outcome.
- upd_target  in  32  actual branch target.
- upd_mispredict  in  1  EX detected a misprediction; used only for statistics.
- flush  in  1  synchronous invalidate-all, used on kernel entry and exceptions.
- stat_updates  out  32  count of accepted updates.
- stat_mispredicts  out  32  count of accepted updates with upd_mispredict = 1.

## Operation
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2]. The tag includes bit 31 (kernel bit), so user and kernel code never alias.
- Each entry holds: valid, tag, target[31:0], cnt[CNT_W-1:0].
- Lookup:
  - hit = valid[index] and tag match.
  - pred_taken = hit and cnt[CNT_W-1].
  - pred_target = target on hit, 0 otherwise.
  - Purely combinational; no state change.
- Update, on a rising edge with upd_valid = 1 and flush = 0:
  - Hit, taken: cnt saturating +1 (stops at 2^CNT_W-1); target <= upd_target.
  - Hit, not taken: cnt saturating -1 (stops at 0); target unchanged.
  - Miss, taken: allocate the entry, overwriting any valid entry. valid <= 1, tag <= upd tag, target <= upd_target, cnt <= 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no change.
- Flush: all valid bits <= 0 on the next edge. Flush has priority over an update in the same cycle; that update is dropped and not counted in the statistics.
- Reset values:
  - All valid bits 0.
  - All cnt = 2^(CNT_W-1)-1 (weakly not taken). For CNT_W = 1 this is 0.
  - Tags and targets 0.
  - stat_updates and stat_mispredicts = 0.
  - Consequently pred_taken = 0 and pred_target = 0 immediately after reset.

## Timing
- Lookup latency: 0 cycles, combinational from lk_pc.
- Update latency: 1 cycle. A write on edge N is visible to lookups from edge N onward.
- Lookup and update to the same index in the same cycle: the lookup sees pre-update state. There is no write-to-read bypass.
- Reset asserted mid-operation: all state clears asynchronously. Outputs go to reset values immediately, without waiting for a clock edge.
- Statistics counters wrap modulo 2^32.

## Configuration
- BP_STATS_EN defined: stat_updates and stat_mispredicts are implemented as described.
- BP_STATS_EN undefined:
  - No counter registers are built.
  - stat_updates and stat_mispredicts are tied to 32'h0.
  - upd_mispredict is ignored.
  - The port list is identical in both builds.

## Test plan
All scenarios use ENTRIES = 16 and CNT_W = 2, so index = pc[5:2] and tag = pc[31:6].
- Reset state: after reset, lk_pc = 32'h80000010 -> pred_taken = 0, pred_target = 32'h0.
- Allocate: update pc 32'h80000010, taken, target 32'h80000040 -> next cycle, lookup at 32'h80000010 gives pred_taken = 1, pred_target = 32'h80000040 (cnt = 2'b10).
- Saturation:
  - Three not-taken updates to that PC -> cnt goes 01, then 00, then stays 00; pred_taken = 0 throughout.
  - Four taken updates -> cnt reaches 11 and stays at 11.
- Aliasing: with the allocated entry present, lookup at 32'h80000050 (same index 4, different tag) -> pred_taken = 0. A taken update at 32'h80000050 with target 32'h80000100 replaces the entry; 32'h80000010 then misses.
- Priority and same-cycle cases:
  - flush and a taken update in the same cycle -> all lookups miss next cycle, and stat_updates does not increment.
  - Lookup and update to the same index in the same cycle -> pred_taken shows the old value.
- Stats and reset: with BP_STATS_EN defined, 5 updates of which 2 have upd_mispredict = 1 -> stat_updates = 5, stat_mispredicts = 2. Asserting reset between clock edges -> both read 0 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters; combinational IF lookup, EX-trained.
// Define BP_STATS_EN to build the update/mispredict statistics counters (tied to zero otherwise).
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lk_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        flush,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_d    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup reads registered state only, so a same-cycle update is never bypassed.
  assign pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target = lk_hit ? target_q[lk_idx] : 32'h0;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (cnt_q[upd_idx] != CNT_MAX) cnt_d[upd_idx] = cnt_q[upd_idx] + 1'b1;
          target_d[upd_idx] = upd_target;
        end else if (cnt_q[upd_idx] != '0) begin
          cnt_d[upd_idx] = cnt_q[upd_idx] - 1'b1;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        cnt_d[upd_idx]    = CNT_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RST;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_upd_q, stat_upd_d, stat_mis_q, stat_mis_d;
  logic        unused_bits;

  assign unused_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  // An update dropped by a concurrent flush is not counted.
  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (upd_valid && !flush) begin
      stat_upd_d = stat_upd_q + 32'd1;
      if (upd_mispredict) stat_mis_d = stat_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_mis_q;
`else
  logic unused_bits;

  assign unused_bits      = ^{lk_pc[1:0], upd_pc[1:0], upd_mispredict};
  assign stat_updates     = 32'h0;
  assign stat_mispredicts = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor (ENTRIES=16, CNT_W=2) against a table-level model.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] lk_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] stat_updates, stat_mispredicts;

  int n_chk = 0;
  int n_fail = 0;

  branch_predictor #(.ENTRIES(16), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .lk_pc(lk_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush(flush),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Reference table: counters held as plain integers 0..3, taken when in the upper half.
  bit          m_val [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_cnt [16];
  int unsigned m_upd, m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_val[idx_of(pc)] && (m_tag[idx_of(pc)] == (pc >> 6));
  endfunction

  function automatic logic [31:0] exp_upd();
`ifdef BP_STATS_EN
    return m_upd;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_mis();
`ifdef BP_STATS_EN
    return m_mis;
`else
    return 32'h0;
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_upd = 0; m_mis = 0;
  endtask

  task automatic m_clock();
    int i;
    i = idx_of(upd_pc);
    if (flush) begin
      for (int k = 0; k < 16; k++) m_val[k] = 0;
    end else if (upd_valid) begin
      m_upd++;
      if (upd_mispredict) m_mis++;
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (upd_taken) begin
        m_val[i] = 1; m_tag[i] = upd_pc >> 6; m_tgt[i] = upd_target; m_cnt[i] = 2;
      end
    end
  endtask

  task automatic drive(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic um, input logic fl);
    lk_pc = lk; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_mispredict = um; flush = fl;
  endtask

  // Compare at the falling edge against pre-edge model state, then advance model with the edge.
  task automatic tick();
    bit h;
    @(negedge clk);
    h = m_hit(lk_pc);
    chk("pred_taken", {31'b0, pred_taken}, {31'b0, h && (m_cnt[idx_of(lk_pc)] >= 2)});
    chk("pred_target", pred_target, h ? m_tgt[idx_of(lk_pc)] : 32'h0);
    chk("stat_updates", stat_updates, exp_upd());
    chk("stat_mispredicts", stat_mispredicts, exp_mis());
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic um);
    drive(pc, 1'b1, pc, t, tgt, um, 1'b0);
    tick();
    drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic expect_pred(input string tag, input logic [31:0] pc, input logic et,
                             input logic [31:0] etgt);
    lk_pc = pc; upd_valid = 1'b0; flush = 1'b0;
    #1;
    chk({tag, "_taken"}, {31'b0, pred_taken}, {31'b0, et});
    chk({tag, "_target"}, pred_target, etgt);
  endtask

  initial begin
    logic [31:0] s_upd, s_mis;
    logic [31:0] tags [3];
    m_reset();
    #12 reset = 1'b0;
    @(posedge clk); #1;

    expect_pred("rst", 32'h80000010, 1'b0, 32'h0);
    chk("rst_stat_upd", stat_updates, 32'h0);
    chk("rst_stat_mis", stat_mispredicts, 32'h0);

    upd(32'h80000010, 1'b1, 32'h80000040, 1'b0);
    expect_pred("alloc", 32'h80000010, 1'b1, 32'h80000040);

    for (int k = 0; k < 3; k++) begin
      upd(32'h80000010, 1'b0, 32'h0, 1'b0);
      expect_pred("sat_down", 32'h80000010, 1'b0, 32'h80000040);
    end
    upd(32'h80000010, 1'b1, 32'h80000040, 1'b0);
    expect_pred("up1", 32'h80000010, 1'b0, 32'h80000040);
    for (int k = 0; k < 3; k++) begin
      upd(32'h80000010, 1'b1, 32'h80000040, 1'b0);
      expect_pred("up_sat", 32'h80000010, 1'b1, 32'h80000040);
    end
    // Saturated at 3: one not-taken still predicts taken, the second does not.
    upd(32'h80000010, 1'b0, 32'h0, 1'b0);
    expect_pred("from_max1", 32'h80000010, 1'b1, 32'h80000040);
    upd(32'h80000010, 1'b0, 32'h0, 1'b0);
    expect_pred("from_max2", 32'h80000010, 1'b0, 32'h80000040);

    expect_pred("alias_miss", 32'h80000050, 1'b0, 32'h0);
    upd(32'h80000050, 1'b1, 32'h80000100, 1'b0);
    expect_pred("alias_old", 32'h80000010, 1'b0, 32'h0);
    expect_pred("alias_new", 32'h80000050, 1'b1, 32'h80000100);

    s_upd = stat_updates;
    drive(32'h0, 1'b1, 32'h80000020, 1'b1, 32'h80000200, 1'b1, 1'b1);
    tick();
    expect_pred("flush_a", 32'h80000050, 1'b0, 32'h0);
    expect_pred("flush_b", 32'h80000020, 1'b0, 32'h0);
    chk("flush_stat", stat_updates, s_upd);

    upd(32'h80000030, 1'b1, 32'h80000300, 1'b0);
    drive(32'h80000030, 1'b1, 32'h80000030, 1'b0, 32'h0, 1'b0, 1'b0);
    #1 chk("same_cyc_old", {31'b0, pred_taken}, 32'h1);
    tick();
    expect_pred("same_cyc_new", 32'h80000030, 1'b0, 32'h80000300);
    drive(32'h00000034, 1'b1, 32'h00000034, 1'b1, 32'h00000400, 1'b0, 1'b0);
    #1 chk("same_cyc_alloc", {31'b0, pred_taken}, 32'h0);
    tick();
    expect_pred("kernel_alias", 32'h80000034, 1'b0, 32'h0);

    s_upd = m_upd; s_mis = m_mis;
    for (int k = 0; k < 5; k++) upd(32'h80000060 + 32'(k * 4), 1'b1, 32'h1000, k == 1 || k == 3);
`ifdef BP_STATS_EN
    chk("stat5_upd", stat_updates - s_upd, 32'd5);
    chk("stat5_mis", stat_mispredicts - s_mis, 32'd2);
`else
    chk("stat5_upd", stat_updates, 32'd0);
    chk("stat5_mis", stat_mispredicts, 32'd0);
`endif

    lk_pc = 32'h80000060;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_upd", stat_updates, 32'h0);
    chk("async_rst_mis", stat_mispredicts, 32'h0);
    chk("async_rst_pred", {31'b0, pred_taken}, 32'h0);
    chk("async_rst_tgt", pred_target, 32'h0);
    m_reset();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); m_clock(); #1;

    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h2000000;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      a = (tags[$urandom_range(0, 2)] << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      b = ($urandom_range(0, 1) != 0) ? a
        : (tags[$urandom_range(0, 2)] << 6) | ($urandom_range(0, 15) << 2);
      drive(b, $urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0, $urandom,
            $urandom_range(0, 1) != 0, $urandom_range(0, 40) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
